crc_checker: RTL and testbench

- Receive-side counterpart to the CRC transmit driver.
- Walks a word-organised frame buffer (8 × 32-bit words, big-endian bytes) and feeds the payload bytes through the shared crc16 engine.
- Fetches the two trailing received-CRC bytes, compares them with the computed CRC, and reports pass/fail through a level done handshake.
- Sits between the frame RX buffer and the control/status register block.

---
 rtl/crc_pkg.sv | 28 ++
 rtl/crc_checker_crc16.sv | 41 ++++
 rtl/crc_checker.sv | 173 +++++++++++++++++
 tb/tb_crc_checker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and constants for the receive-side CRC checker.
package crc_pkg;

  localparam int unsigned MAX_LEN        = 29;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BUF_WORDS      = 8;
  localparam int unsigned ADDR_W         = $clog2(BUF_WORDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPUTE = 3'd1,
    GET_HI  = 3'd2,
    GET_LO  = 3'd3,
    CHECK   = 3'd4,
    DONE    = 3'd5
  } state_e;

  // Buffer words are big-endian: byte 0 of a word sits in the top byte lane.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/crc_checker_crc16.sv
// Shared crc16 engine (CCITT polynomial 0x1021, MSB first, start value {seed,seed}).
// Same engine as the transmit side so both ends agree bit for bit.
module crc16 (
  input  logic        clk,
  input  logic        nrst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  input  logic [7:0]  seed,
  output logic [15:0] crc
);

  localparam logic [15:0] POLY = 16'h1021;

  logic [15:0] crc_q, crc_d;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (init)    crc_d = {seed, seed};
    else if (en) crc_d = crc_byte(crc_q, data);
  end

  always_ff @(posedge clk) begin
    if (!nrst) crc_q <= {seed, seed};
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc_checker.sv
// Receive CRC checker: streams frame payload through crc16, fetches trailing CRC, reports pass/fail.
// Optional error counter output enabled by CRC_CHECKER_ERRCNT_EN.
module crc_checker
  import crc_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  input  logic [31:0] data,
  output logic [2:0]  addr,
  input  logic [7:0]  seed,
  input  logic [7:0]  length,
  output logic        done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        len_err,
  output logic [15:0] rx_crc,
  output logic [15:0] calc_crc
`ifdef CRC_CHECKER_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  state_e      state_q, state_d;
  logic [4:0]  byte_ctr_q, byte_ctr_d;
  logic [4:0]  len_q, len_d;
  logic        res_ok_q, res_ok_d;
  logic        res_err_q, res_err_d;
  logic        res_len_q, res_len_d;
  logic [15:0] rx_crc_q, rx_crc_d;
  logic        done_q, crc_ok_q, crc_err_q, len_err_q;
  logic        len_ok;
  logic [7:0]  cur_byte;
  logic        crc_init, crc_en;

  assign len_ok   = (length <= 8'(MAX_LEN));
  assign addr     = byte_ctr_q[4:2];
  assign cur_byte = byte_sel(data, byte_ctr_q[1:0]);
  assign crc_init = (state_q == IDLE);
  assign crc_en   = (state_q == COMPUTE);

  crc16 u_crc16 (
    .clk  (clk),
    .nrst (nrst),
    .init (crc_init),
    .en   (crc_en),
    .data (cur_byte),
    .seed (seed),
    .crc  (calc_crc)
  );

  always_comb begin
    state_d    = state_q;
    byte_ctr_d = 5'd0;
    len_d      = len_q;
    res_ok_d   = res_ok_q;
    res_err_d  = res_err_q;
    res_len_d  = res_len_q;
    rx_crc_d   = rx_crc_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          res_ok_d  = 1'b0;
          if (len_ok) begin
            len_d     = length[4:0];
            res_err_d = 1'b0;
            res_len_d = 1'b0;
            state_d   = COMPUTE;
          end else begin
            res_err_d = 1'b1;
            res_len_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      COMPUTE: begin
        if (en) begin
          byte_ctr_d = byte_ctr_q + 5'd1;
          // last payload byte is still fed to the engine this cycle
          if (byte_ctr_q == len_q) state_d = GET_HI;
        end
      end
      GET_HI: begin
        if (en) begin
          rx_crc_d[15:8] = cur_byte;
          byte_ctr_d     = byte_ctr_q + 5'd1;
          state_d        = GET_LO;
        end
      end
      GET_LO: begin
        if (en) begin
          rx_crc_d[7:0] = cur_byte;
          state_d       = CHECK;
        end
      end
      CHECK: begin
        if (en) begin
          res_ok_d  = (calc_crc == rx_crc_q);
          res_err_d = (calc_crc != rx_crc_q);
          state_d   = DONE;
        end
      end
      DONE: begin
        if (!en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // abort from any busy state drops all pending results
    if (!en && (state_q inside {COMPUTE, GET_HI, GET_LO, CHECK})) begin
      state_d   = IDLE;
      res_ok_d  = 1'b0;
      res_err_d = 1'b0;
      res_len_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      byte_ctr_q <= 5'd0;
      len_q      <= 5'd0;
      res_ok_q   <= 1'b0;
      res_err_q  <= 1'b0;
      res_len_q  <= 1'b0;
      rx_crc_q   <= 16'h0000;
      done_q     <= 1'b0;
      crc_ok_q   <= 1'b0;
      crc_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_ctr_q <= byte_ctr_d;
      len_q      <= len_d;
      res_ok_q   <= res_ok_d;
      res_err_q  <= res_err_d;
      res_len_q  <= res_len_d;
      rx_crc_q   <= rx_crc_d;
      // flags are only visible while DONE so they are zero whenever done is low
      done_q     <= (state_q == DONE);
      crc_ok_q   <= (state_q == DONE) && res_ok_q;
      crc_err_q  <= (state_q == DONE) && res_err_q;
      len_err_q  <= (state_q == DONE) && res_len_q;
    end
  end

  assign done    = done_q;
  assign crc_ok  = crc_ok_q;
  assign crc_err = crc_err_q;
  assign len_err = len_err_q;
  assign rx_crc  = rx_crc_q;

`ifdef CRC_CHECKER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       err_inc;

  assign err_inc = en && (((state_q == IDLE) && !len_ok) ||
                          ((state_q == CHECK) && (calc_crc != rx_crc_q)));

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!nrst) err_cnt_q <= 8'h00;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_checker.sv
// Directed scoreboard bench for crc_checker with an independent byte-serial CRC model.
module tb_crc_checker;

  logic        clk, nrst, en;
  logic [31:0] data;
  logic [2:0]  addr;
  logic [7:0]  seed, length;
  logic        done, crc_ok, crc_err, len_err;
  logic [15:0] rx_crc, calc_crc;
`ifdef CRC_CHECKER_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  logic [7:0] mem [32];

  assign data = {mem[{addr, 2'd0}], mem[{addr, 2'd1}], mem[{addr, 2'd2}], mem[{addr, 2'd3}]};

  crc_checker dut (
    .clk      (clk),
    .nrst     (nrst),
    .en       (en),
    .data     (data),
    .addr     (addr),
    .seed     (seed),
    .length   (length),
    .done     (done),
    .crc_ok   (crc_ok),
    .crc_err  (crc_err),
    .len_err  (len_err),
    .rx_crc   (rx_crc),
    .calc_crc (calc_crc)
`ifdef CRC_CHECKER_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ok;
    logic        err;
    logic        lerr;
    logic [15:0] rx;
    logic [15:0] calc;
    int          lat;
    bit          chk_rx;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] amask;

  // Reference CRC: XOR byte into the high half, then shift with feedback.
  function automatic logic [15:0] model_crc(input logic [7:0] sd, input int n);
    logic [15:0] c;
    c = {sd, sd};
    for (int k = 0; k < n; k++) begin
      c = c ^ {mem[k], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prep(input int len, input logic [7:0] sd, output logic [15:0] c);
    c = model_crc(sd, len + 1);
    mem[len + 1] = c[15:8];
    mem[len + 2] = c[7:0];
  endtask

  task automatic push(input logic ok, input logic err, input logic lerr, input logic [15:0] rx,
                      input logic [15:0] calc, input int lat, input bit chk_rx);
    exp_t e;
    e.ok = ok; e.err = err; e.lerr = lerr; e.rx = rx; e.calc = calc; e.lat = lat; e.chk_rx = chk_rx;
    sb.push_back(e);
  endtask

  task automatic run_check(input string tag, input logic [7:0] len, input logic [7:0] sd);
    exp_t e;
    int   lat;
    lat    = -1;
    amask  = 8'h00;
    length = len;
    seed   = sd;
    en     = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      amask[addr] = 1'b1;
      if (done) begin
        lat = k;
        break;
      end
    end
    e = sb.pop_front();
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for done (budget 100 cycles)", tag);
    end else begin
      chk({tag, ".latency"}, lat, e.lat);
      chk({tag, ".crc_ok"}, crc_ok, e.ok);
      chk({tag, ".crc_err"}, crc_err, e.err);
      chk({tag, ".len_err"}, len_err, e.lerr);
      chk({tag, ".calc_crc"}, calc_crc, e.calc);
      if (e.chk_rx) chk({tag, ".rx_crc"}, rx_crc, e.rx);
    end
  endtask

  task automatic finish_frame(input string tag);
    en = 1'b0;
    step();
    step();
    chk({tag, ".done_clear"}, done, 1'b0);
  endtask

  initial begin
    logic [15:0] c, cbad;
    int          done_seen;

    nrst = 1'b0; en = 1'b0; length = 8'd0; seed = 8'h00;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    step();
    step();
    chk("rst.done", done, 1'b0);
    chk("rst.crc_ok", crc_ok, 1'b0);
    chk("rst.crc_err", crc_err, 1'b0);
    chk("rst.len_err", len_err, 1'b0);
    chk("rst.rx_crc", rx_crc, 16'h0000);
    chk("rst.calc_crc", calc_crc, model_crc(8'h00, 0));
`ifdef CRC_CHECKER_ERRCNT_EN
    chk("rst.err_count", err_count, 8'd0);
`endif
    nrst = 1'b1;
    step();
    chk("idle.addr", addr, 3'd0);

    // clean frame, length 3
    mem[0] = 8'hDE; mem[1] = 8'hAD; mem[2] = 8'hBE; mem[3] = 8'hEF;
    prep(3, 8'h00, c);
    push(1'b1, 1'b0, 1'b0, c, c, 8, 1'b1);
    run_check("clean", 8'd3, 8'h00);
    repeat (3) step();
    chk("clean.hold_done", done, 1'b1);
    chk("clean.hold_ok", crc_ok, 1'b1);
    finish_frame("clean");
    chk("clean.ok_clear", crc_ok, 1'b0);

    // corrupt payload byte, trailer still holds the clean CRC
    mem[2] = 8'hBF;
    cbad = model_crc(8'h00, 4);
    push(1'b0, 1'b1, 1'b0, c, cbad, 8, 1'b1);
    run_check("corrupt", 8'd3, 8'h00);
    finish_frame("corrupt");
    mem[2] = 8'hBE;

    // boundary: CRC occupies the last two bytes of word 7
    for (int i = 0; i < 30; i++) mem[i] = 8'($urandom);
    prep(29, 8'hA5, c);
    push(1'b1, 1'b0, 1'b0, c, c, 34, 1'b1);
    run_check("maxlen", 8'd29, 8'hA5);
    chk("maxlen.addr_cover", amask, 8'hFF);
    finish_frame("maxlen");

    // illegal length
    push(1'b0, 1'b1, 1'b1, 16'h0000, model_crc(8'h3C, 0), 1, 1'b0);
    run_check("badlen", 8'd30, 8'h3C);
    chk("badlen.addr_cover", amask, 8'h01);
    finish_frame("badlen");

    // abort at edge 3 of a length-10 check
    for (int i = 0; i < 11; i++) mem[i] = 8'($urandom);
    prep(10, 8'h33, c);
    length = 8'd10; seed = 8'h33; en = 1'b1;
    repeat (3) step();
    en = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done || crc_ok || crc_err) done_seen++;
    end
    chk("abort.no_done", done_seen, 0);
    chk("abort.calc_init", calc_crc, model_crc(8'h33, 0));
    chk("abort.addr", addr, 3'd0);

    // restart completes normally, then reset while in DONE
    push(1'b1, 1'b0, 1'b0, c, c, 15, 1'b1);
    run_check("restart", 8'd10, 8'h33);
`ifdef CRC_CHECKER_ERRCNT_EN
    chk("errcnt.before_rst", err_count, 8'd2);
`endif
    nrst = 1'b0;
    step();
    chk("rstdone.done", done, 1'b0);
    chk("rstdone.crc_ok", crc_ok, 1'b0);
    chk("rstdone.crc_err", crc_err, 1'b0);
    chk("rstdone.len_err", len_err, 1'b0);
    chk("rstdone.rx_crc", rx_crc, 16'h0000);
    chk("rstdone.calc_crc", calc_crc, model_crc(8'h33, 0));
`ifdef CRC_CHECKER_ERRCNT_EN
    chk("rstdone.err_count", err_count, 8'd0);
`endif
    nrst = 1'b1;
    en = 1'b0;
    step();

`ifdef CRC_CHECKER_ERRCNT_EN
    // error counter saturation
    mem[0] = 8'hDE; mem[1] = 8'hAD; mem[2] = 8'hBE; mem[3] = 8'hEF;
    prep(3, 8'h00, c);
    mem[2] = 8'hBF;
    cbad = model_crc(8'h00, 4);
    for (int n = 0; n < 257; n++) begin
      push(1'b0, 1'b1, 1'b0, c, cbad, 8, 1'b1);
      run_check("sat", 8'd3, 8'h00);
      finish_frame("sat");
      if (n == 9) chk("errcnt.ten", err_count, 8'd10);
    end
    chk("errcnt.saturate", err_count, 8'd255);
    mem[2] = 8'hBE;
    push(1'b1, 1'b0, 1'b0, c, c, 8, 1'b1);
    run_check("sat_clean", 8'd3, 8'h00);
    finish_frame("sat_clean");
    chk("errcnt.clean_hold", err_count, 8'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
